// File: rtl/lcd_bus_receiver.sv
// Receive-side monitor for the HD44780 4-bit LCD bus.
// Decodes E strobes into bytes and keeps a 2x16 DDRAM shadow.
module lcd_bus_receiver #(
  parameter int unsigned E_MIN_HIGH = 2,
  parameter logic [7:0]  SPACE_CHAR = 8'h20,
  parameter int unsigned CLR_CYCLES = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         LCD_E,
  input  logic         LCD_RS,
  input  logic         LCD_RW,
  input  logic [3:0]   LCD_D,
  output logic [127:0] row_A,
  output logic [127:0] row_B,
  output logic         byte_valid,
  output logic [7:0]   last_byte,
  output logic         last_rs,
  output logic [6:0]   ddram_addr,
  output logic         busy,
  output logic         overrun
);

  localparam int unsigned ECNT_W = $clog2(E_MIN_HIGH + 1);
  localparam int unsigned CLR_W  = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam int unsigned CELLS  = 32;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e            state_q;
  logic [ECNT_W-1:0] e_cnt_q;
  logic [3:0]        d_lat_q;
  logic              rs_lat_q;
  logic              rw_lat_q;
  logic              mode8_q;
  logic              phase_lo_q;
  logic              id_q;
  logic [3:0]        hi_nib_q;
  logic              hi_rs_q;
  logic [CLR_W-1:0]  clr_cnt_q;
  logic [7:0]        cell_q [CELLS];
  logic              byte_valid_q;
  logic [7:0]        last_byte_q;
  logic              last_rs_q;
  logic [6:0]        addr_q;
  logic              busy_q;
  logic              overrun_q;

  logic       strobe_c;
  logic [7:0] byte_c;
  logic       byte_rs_c;
  logic [6:0] addr_next_c;

  // Address step after a data byte, with the two-line wrap points
  function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)      r = 7'h40;
      else if (a == 7'h67) r = 7'h00;
      else                 r = a + 7'd1;
    end else begin
      if (a == 7'h00)      r = 7'h67;
      else if (a == 7'h40) r = 7'h27;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  // A strobe is the first low sample after a long-enough high run; RW=1 strobes vanish
  always_comb begin
    strobe_c    = !LCD_E && (e_cnt_q >= ECNT_W'(E_MIN_HIGH)) && !rw_lat_q;
    byte_c      = mode8_q ? {d_lat_q, 4'h0} : {hi_nib_q, d_lat_q};
    byte_rs_c   = mode8_q ? rs_lat_q : hi_rs_q;
    addr_next_c = addr_step(addr_q, id_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      e_cnt_q      <= '0;
      d_lat_q      <= '0;
      rs_lat_q     <= 1'b0;
      rw_lat_q     <= 1'b0;
      mode8_q      <= 1'b1;
      phase_lo_q   <= 1'b0;
      id_q         <= 1'b1;
      hi_nib_q     <= '0;
      hi_rs_q      <= 1'b0;
      clr_cnt_q    <= '0;
      byte_valid_q <= 1'b0;
      last_byte_q  <= '0;
      last_rs_q    <= 1'b0;
      addr_q       <= '0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < CELLS; i++) cell_q[i] <= SPACE_CHAR;
    end else begin
      byte_valid_q <= 1'b0;

      if (LCD_E) begin
        if (e_cnt_q < ECNT_W'(E_MIN_HIGH)) e_cnt_q <= e_cnt_q + ECNT_W'(1);
        d_lat_q  <= LCD_D;
        rs_lat_q <= LCD_RS;
        rw_lat_q <= LCD_RW;
      end else begin
        e_cnt_q <= '0;
      end

      case (state_q)
        ST_IDLE: begin
          if (strobe_c) begin
            if (!mode8_q && !phase_lo_q) begin
              hi_nib_q   <= d_lat_q;
              hi_rs_q    <= rs_lat_q;
              phase_lo_q <= 1'b1;
            end else begin
              phase_lo_q   <= 1'b0;
              byte_valid_q <= 1'b1;
              last_byte_q  <= byte_c;
              last_rs_q    <= byte_rs_c;
              if (byte_rs_c) begin
                if (addr_q[5:4] == 2'b00) cell_q[{addr_q[6], addr_q[3:0]}] <= byte_c;
                addr_q <= addr_next_c;
              end else if (byte_c[7]) begin
                addr_q <= byte_c[6:0];
              end else if (byte_c[6]) begin
                addr_q <= addr_q;
              end else if (byte_c[5]) begin
                // Phase already returns to HI on every completed byte
                mode8_q <= byte_c[4];
              end else if (byte_c[4] || byte_c[3]) begin
                addr_q <= addr_q;
              end else if (byte_c[2]) begin
                id_q <= byte_c[1];
              end else if (byte_c[1]) begin
                addr_q <= '0;
              end else if (byte_c[0]) begin
                state_q   <= ST_CLEAR;
                busy_q    <= 1'b1;
                clr_cnt_q <= '0;
              end
            end
          end
        end
        ST_CLEAR: begin
          cell_q[5'(clr_cnt_q)] <= SPACE_CHAR;
          if (strobe_c) overrun_q <= 1'b1;
          if (clr_cnt_q == CLR_W'(CLR_CYCLES - 1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            addr_q  <= '0;
            id_q    <= 1'b1;
          end else begin
            clr_cnt_q <= clr_cnt_q + CLR_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Shadow cells 0..15 are line 1, 16..31 line 2; column 0 sits in the top byte
  always_comb begin
    row_A = '0;
    row_B = '0;
    for (int c = 0; c < 16; c++) begin
      row_A[127-8*c -: 8] = cell_q[c];
      row_B[127-8*c -: 8] = cell_q[16+c];
    end
  end

  assign byte_valid = byte_valid_q;
  assign last_byte  = last_byte_q;
  assign last_rs    = last_rs_q;
  assign ddram_addr = addr_q;
  assign busy       = busy_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Bench for lcd_bus_receiver: directed scenarios plus random strobes
// checked against a byte-level model of the LCD bus rules.
module tb_lcd_bus_receiver;

  localparam int unsigned E_MIN = 2;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         LCD_E, LCD_RS, LCD_RW;
  logic [3:0]   LCD_D;
  logic [127:0] row_A, row_B;
  logic         byte_valid;
  logic [7:0]   last_byte;
  logic         last_rs;
  logic [6:0]   ddram_addr;
  logic         busy;
  logic         overrun;

  lcd_bus_receiver dut (
    .clk(clk), .reset_n(reset_n),
    .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW), .LCD_D(LCD_D),
    .row_A(row_A), .row_B(row_B),
    .byte_valid(byte_valid), .last_byte(last_byte), .last_rs(last_rs),
    .ddram_addr(ddram_addr), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int busy_cnt = 0;

  always @(negedge clk) if (busy === 1'b1) busy_cnt++;

  // Reference model state
  logic [7:0] m_cell [32];
  int         m_addr;
  bit         m_id, m_mode8, m_phase_lo, m_hi_rs, m_busy, m_overrun, m_last_rs;
  logic [3:0] m_hi;
  logic [7:0] m_last_byte;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] m_row(input int base);
    logic [127:0] r;
    for (int c = 0; c < 16; c++) r[127-8*c -: 8] = m_cell[base+c];
    return r;
  endfunction

  task automatic m_fill_spaces();
    for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
  endtask

  task automatic m_reset();
    m_fill_spaces();
    m_addr = 0; m_id = 1; m_mode8 = 1; m_phase_lo = 0; m_hi = 4'h0; m_hi_rs = 0;
    m_busy = 0; m_overrun = 0; m_last_byte = 8'h00; m_last_rs = 0;
  endtask

  task automatic m_byte(input logic [7:0] b, input bit rs);
    int a;
    a = m_addr;
    m_last_byte = b;
    m_last_rs   = rs;
    if (rs) begin
      if (a <= 15) m_cell[a] = b;
      else if (a >= 64 && a <= 79) m_cell[a - 48] = b;
      if (m_id) a = (a == 39) ? 64 : (a == 103) ? 0 : (a + 1) % 128;
      else      a = (a == 0) ? 103 : (a == 64) ? 39 : a - 1;
      m_addr = a;
    end else if (b[7]) m_addr = int'(b[6:0]);
    else if (b[6]) begin end
    else if (b[5]) begin
      if (m_mode8 != b[4]) m_phase_lo = 0;
      m_mode8 = b[4];
    end
    else if (b[4] || b[3]) begin end
    else if (b[2]) m_id = b[1];
    else if (b[1]) m_addr = 0;
    else if (b[0]) m_busy = 1;
  endtask

  task automatic m_strobe(input bit rs, input bit rw, input logic [3:0] d, input int hi, output bit done);
    done = 0;
    if (hi < int'(E_MIN) || rw) return;
    if (m_busy) begin m_overrun = 1; return; end
    if (m_mode8) begin
      m_byte({d, 4'h0}, rs); done = 1;
    end else if (!m_phase_lo) begin
      m_hi = d; m_hi_rs = rs; m_phase_lo = 1;
    end else begin
      m_phase_lo = 0; m_byte({m_hi, d}, m_hi_rs); done = 1;
    end
  endtask

  task automatic compare_all();
    chk("ddram_addr", 128'(ddram_addr), 128'(m_addr));
    chk("last_byte", 128'(last_byte), 128'(m_last_byte));
    chk("last_rs", 128'(last_rs), 128'(m_last_rs));
    chk("overrun", 128'(overrun), 128'(m_overrun));
    chk("busy", 128'(busy), 128'(m_busy));
    if (!m_busy) begin
      chk("row_A", row_A, m_row(0));
      chk("row_B", row_B, m_row(16));
    end
  endtask

  // One E pulse of 'hi' cycles; bus lines are scrambled once E drops
  task automatic xfer(input bit rs, input bit rw, input logic [3:0] d, input int hi);
    bit done;
    LCD_E = 1'b1; LCD_RS = rs; LCD_RW = rw; LCD_D = d;
    repeat (hi) @(negedge clk);
    LCD_E = 1'b0; LCD_RS = 1'($urandom); LCD_D = 4'($urandom);
    @(negedge clk);
    m_strobe(rs, rw, d, hi, done);
    chk("byte_valid", 128'(byte_valid), 128'(done));
  endtask

  task automatic send_byte(input bit rs, input logic [7:0] b);
    if (m_mode8) xfer(rs, 1'b0, b[7:4], 2);
    else begin
      xfer(rs, 1'b0, b[7:4], 2);
      xfer(rs, 1'b0, b[3:0], 2);
    end
  endtask

  task automatic wait_clear();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("clear_timeout", 128'(n < 100), 128'(1));
    m_fill_spaces();
    m_addr = 0; m_id = 1; m_busy = 0;
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0; LCD_E = 1'b0;
    repeat (cycles) @(negedge clk);
    reset_n = 1'b1;
    m_reset();
  endtask

  task automatic random_phase(input int n);
    bit rs, rw;
    logic [3:0] d;
    int hi;
    for (int i = 0; i < n; i++) begin
      rs = 1'($urandom);
      rw = ($urandom_range(0, 7) == 0);
      d  = 4'($urandom);
      hi = $urandom_range(1, 4);
      xfer(rs, rw, d, hi);
      if (m_busy) wait_clear();
      compare_all();
    end
  endtask

  logic [127:0] saved_a;
  int           b0;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0; LCD_D = 4'h0;
    @(negedge clk);
    do_reset(2);
    compare_all();
    chk("reset_rowA", row_A, {16{8'h20}});
    chk("reset_bv", 128'(byte_valid), 128'(0));

    // T1 init sequence and "Fibo"
    xfer(0, 0, 4'h3, 2); xfer(0, 0, 4'h3, 2); xfer(0, 0, 4'h3, 2); xfer(0, 0, 4'h2, 2);
    send_byte(0, 8'h28); send_byte(0, 8'h06); send_byte(0, 8'h80);
    send_byte(1, "F"); send_byte(1, "i"); send_byte(1, "b"); send_byte(1, "o");
    chk("T1_fibo", 128'(row_A[127:96]), 128'(32'h4669626F));
    chk("T1_addr", 128'(ddram_addr), 128'(7'h04));
    chk("T1_rs", 128'(last_rs), 128'(1));
    compare_all();

    // T2 row B
    saved_a = row_A;
    send_byte(0, 8'hC0); send_byte(1, "#"); send_byte(1, "0"); send_byte(1, "1");
    chk("T2_rowB", 128'(row_B[127:104]), 128'(24'h233031));
    chk("T2_rowA", row_A, saved_a);
    compare_all();

    // T3 clear with an overrun strobe
    b0 = busy_cnt;
    send_byte(0, 8'h01);
    chk("T3_busy", 128'(busy), 128'(1));
    xfer(1, 0, 4'h5, 2);
    wait_clear();
    chk("T3_busy_cycles", 128'(busy_cnt - b0), 128'(32));
    chk("T3_rowA", row_A, {16{8'h20}});
    chk("T3_rowB", row_B, {16{8'h20}});
    chk("T3_addr", 128'(ddram_addr), 128'(0));
    chk("T3_overrun", 128'(overrun), 128'(1));
    compare_all();

    // T4 address wrap in both directions
    send_byte(0, 8'h8F); send_byte(1, "A"); send_byte(1, "B");
    chk("T4_col15", 128'(row_A[7:0]), 128'(8'h41));
    chk("T4_addr11", 128'(ddram_addr), 128'(7'h11));
    send_byte(0, 8'hA7); send_byte(1, "C");
    chk("T4_addr40", 128'(ddram_addr), 128'(7'h40));
    send_byte(0, 8'h04); send_byte(1, "D");
    chk("T4_rowB0", 128'(row_B[127:120]), 128'(8'h44));
    chk("T4_addr27", 128'(ddram_addr), 128'(7'h27));
    compare_all();

    // T5 glitch and read strobes leave the phase alone
    xfer(0, 0, 4'hF, 1);
    xfer(0, 1, 4'h9, 3);
    send_byte(1, "E");
    chk("T5_byte", 128'(last_byte), 128'(8'h45));
    chk("T5_rs", 128'(last_rs), 128'(1));
    compare_all();

    // T6 reset with a pending high nibble
    xfer(0, 0, 4'h4, 2);
    do_reset(1);
    chk("T6_rowA", row_A, {16{8'h20}});
    chk("T6_overrun", 128'(overrun), 128'(0));
    xfer(0, 0, 4'h3, 2);
    chk("T6_byte", 128'(last_byte), 128'(8'h30));
    compare_all();

    // Random strobes from both bus modes
    random_phase(300);
    send_byte(0, 8'h28);
    random_phase(300);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
